// File: rtl/adder_sum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : adder_sum_fifo
// Purpose  : Capture stage for the registered adder. Buffers each valid sum in
//            a first-word-fall-through FIFO and presents it on a valid/ready
//            stream. Also keeps a wrapping running total of accepted sums and
//            a saturating count of sums dropped because the FIFO was full.
// Ports    : clk        - clock, rising edge active
//            rst        - asynchronous active-high reset
//            in_valid   - in_sum carries a new adder result
//            in_sum     - adder result, WIDTH+1 bits
//            out_valid  - FIFO head is valid
//            out_data   - FIFO head entry (combinational read)
//            out_ready  - consumer accepts the head
//            full       - FIFO holds DEPTH entries
//            empty      - FIFO holds no entries
//            count      - current occupancy
//            acc_total  - running sum of accepted entries, modulo 2^ACC_W
//            drop_cnt   - rejected pushes, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module adder_sum_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH:0]             in_sum,
  output logic                       out_valid,
  output logic [WIDTH:0]             out_data,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ACC_W-1:0]           acc_total,
  output logic [7:0]                 drop_cnt
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  // Storage is deliberately left out of reset; occupancy alone decides
  // which entries are meaningful.
  logic [WIDTH:0]    r_mem [DEPTH];
  logic [C_AW-1:0]   r_wr_ptr;
  logic [C_AW-1:0]   r_rd_ptr;
  logic [C_CW-1:0]   r_count;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_drop;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_CW'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle,
  // which keeps sustained one-in/one-out throughput at full occupancy.
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && !w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_acc    <= r_acc + ACC_W'(in_sum);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign acc_total = r_acc;
  assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_adder_sum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sum_fifo
// Purpose  : Self-checking bench for adder_sum_fifo. A queue holds the entries
//            the FIFO should contain; the model updates it each edge and the
//            DUT head, occupancy, flags, total and drop count are compared.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_sum_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int ACC_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH:0]    in_sum = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [WIDTH:0]    out_data;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [ACC_W-1:0]  acc_total;
  logic [7:0]        drop_cnt;

  adder_sum_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .acc_total (acc_total),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0]   q[$];
  logic [ACC_W-1:0] m_acc  = '0;
  int               m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic check_state();
    chk("count",     32'(count),     32'(q.size()));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("acc_total", 32'(acc_total), 32'(m_acc));
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic reset_model();
    q.delete();
    m_acc  = '0;
    m_drop = 0;
  endtask

  // Drive one cycle of stimulus, advance past the edge, update the model.
  task automatic cycle(input logic v, input logic [WIDTH:0] s, input logic r);
    logic pop;
    logic push;
    in_valid  = v;
    in_sum    = s;
    out_ready = r;
    pop  = (q.size() > 0) && r;
    push = v && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(s);
      m_acc = m_acc + ACC_W'(s);
    end else if (v && m_drop < 255) begin
      m_drop++;
    end
    check_state();
  endtask

  task automatic hw_reset();
    rst = 1'b1;
    #1;
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
  endtask

  initial begin
    logic [WIDTH:0] ord [4];
    logic [WIDTH:0] prev;
    logic [ACC_W-1:0] exp8;
    int v;
    ord = '{9'd3, 9'd255, 9'd510, 9'd0};

    // Asynchronous reset, asserted between clock edges
    #3 rst = 1'b1;
    #1;
    reset_model();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_acc",       32'(acc_total), 32'd0);
    chk("rst_drop",      32'(drop_cnt),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0);
      chk("idle_empty", 32'(empty), 32'd1);
    end

    // Ordering
    for (int i = 0; i < 4; i++) cycle(1'b1, ord[i], 1'b0);
    chk("ord_count", 32'(count),     32'd4);
    chk("ord_acc",   32'(acc_total), 32'd768);
    for (int i = 0; i < 4; i++) begin
      chk("ord_head", 32'(out_data), 32'(ord[i]));
      cycle(1'b0, '0, 1'b1);
    end
    chk("ord_empty", 32'(empty), 32'd1);

    // Fill and drop
    hw_reset();
    for (int i = 1; i <= 10; i++) cycle(1'b1, 9'(i), 1'b0);
    chk("fill_full", 32'(full),      32'd1);
    chk("fill_drop", 32'(drop_cnt),  32'd2);
    chk("fill_acc",  32'(acc_total), 32'd36);
    for (int i = 1; i <= 8; i++) begin
      chk("fill_head", 32'(out_data), 32'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("fill_empty", 32'(empty), 32'd1);

    // Full push+pop
    for (int i = 1; i <= 8; i++) cycle(1'b1, 9'(i), 1'b0);
    chk("fpp_full_before", 32'(full), 32'd1);
    cycle(1'b1, 9'd9, 1'b1);
    chk("fpp_count", 32'(count),    32'd8);
    chk("fpp_drop",  32'(drop_cnt), 32'd2);
    for (int i = 2; i <= 9; i++) begin
      chk("fpp_head", 32'(out_data), 32'(i));
      cycle(1'b0, '0, 1'b1);
    end

    // Empty push+pop, then pointer wrap with back-to-back traffic
    chk("epp_empty_before", 32'(empty), 32'd1);
    cycle(1'b1, 9'd7, 1'b1);
    chk("epp_valid", 32'(out_valid), 32'd1);
    chk("epp_data",  32'(out_data),  32'd7);
    chk("epp_count", 32'(count),     32'd1);
    prev = 9'd7;
    for (int i = 0; i < 20; i++) begin
      v = (i * 53 + 11) % 512;
      chk("wrap_head", 32'(out_data), 32'(prev));
      cycle(1'b1, 9'(v), 1'b1);
      prev = 9'(v);
    end
    chk("wrap_count", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b1);

    // Drop counter saturation
    hw_reset();
    exp8 = '0;
    for (int i = 0; i < 300; i++) begin
      v = (i * 97 + 300) % 512;
      if (i < 8) exp8 = exp8 + ACC_W'(v);
      cycle(1'b1, 9'(v), 1'b0);
    end
    chk("sat_drop", 32'(drop_cnt),  32'd255);
    chk("sat_acc",  32'(acc_total), 32'(exp8));
    cycle(1'b1, 9'd1, 1'b0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);

    // Mid-run reset with 5 entries queued
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk("mid_count_before", 32'(count), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_count", 32'(count),     32'd0);
    chk("mid_drop",  32'(drop_cnt),  32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 9'd42, 1'b0);
    chk("mid_head",  32'(out_data), 32'd42);
    chk("mid_alone", 32'(count),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_sum_fifo.md
# adder_sum_fifo

Downstream capture stage for the registered adder. It accepts each `sum` the adder produces (qualified by a valid strobe), buffers the results in a first-word-fall-through FIFO and presents them on a valid/ready stream to the consumer. It also keeps a wrapping running total of accepted sums and a saturating count of sums dropped because the FIFO was full.

## Interface
Parameters:
- `WIDTH`, default 8: adder operand width; sums are `WIDTH+1` bits.
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `ACC_W`, default 16: running-total width; must be at least `WIDTH+1`.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `in_sum` holds a new adder result this cycle. Integration drives this with the adder `en` delayed by the adder latency.
- `in_sum`, input, `WIDTH+1`: adder result.
- `out_valid`, output, 1: FIFO head is valid.
- `out_data`, output, `WIDTH+1`: FIFO head entry.
- `out_ready`, input, 1: consumer accepts the head.
- `full`, output, 1: the FIFO holds `DEPTH` entries.
- `empty`, output, 1: the FIFO holds 0 entries.
- `count`, output, `$clog2(DEPTH)+1`: current occupancy.
- `acc_total`, output, `ACC_W`: running sum of accepted entries.
- `drop_cnt`, output, 8: number of rejected pushes, saturating at 255.

## Operation
Storage:
- `DEPTH`-entry register array.
- Read and write pointers of `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
- Separate occupancy counter `count`.

Transfer conditions:
- pop = `out_valid && out_ready`.
- push = `in_valid && (!full || pop)`. A push into a full FIFO succeeds only when a pop happens in the same cycle.
- drop = `in_valid && !push`.

Updates on each rising edge:
- push: write `in_sum` at the write pointer and advance it. Add `in_sum`, zero-extended, to `acc_total`, modulo `2^ACC_W`.
- pop: advance the read pointer.
- `count`: +1 on push only, -1 on pop only, unchanged on both or neither.
- drop: `drop_cnt` increments unless it is already 255.

Outputs:
- `out_valid` = `!empty`.
- `out_data` = entry at the read pointer (combinational FWFT read). Its value is don't-care when empty; the bench must not check it then.
- `empty` = (`count` == 0); `full` = (`count` == `DEPTH`).

Boundaries:
- Empty with `in_valid` and `out_ready` both high: the push happens and there is no pop, because `out_valid` is low.
- Full with `in_valid` and a pop: the push and pop both happen; `count` stays at `DEPTH` and there is no drop.
- Full with `in_valid` and no pop: the push is dropped and nothing else changes.

Reset:
- `rst` high clears both pointers, `count`, `acc_total` and `drop_cnt` immediately, without waiting for a clock edge.
- After reset, `out_valid`=0, `empty`=1, `full`=0.
- The storage array is not reset.
- Reset asserted mid-stream discards all buffered entries. The first edge after deassertion behaves as an empty FIFO.

## Timing
- Push-to-output latency is 1 cycle. A sum pushed at edge N appears on `out_valid`/`out_data` right after edge N.
- `count`, `full`, `empty` and `acc_total` reflect a push or pop right after the edge that performs it.
- `out_data` changes only on the edge after a pop, or on a push into an empty FIFO.
- Throughput: one push and one pop per cycle, sustained.
- No combinational path from `in_valid` or `in_sum` to any output.
- Combinational path from `out_ready` to internal logic only (push acceptance), not to any output.

## Test plan
- Reset then idle: with `rst` high mid-cycle, outputs clear asynchronously to `out_valid`=0, `empty`=1, `count`=0, `acc_total`=0, `drop_cnt`=0; they hold for 5 idle cycles after release.
- Ordering: push sums 3, 255, 510, 0 with `out_ready`=0. Then `count`=4 and `acc_total`=768. Raise `out_ready`: `out_data` reads 3, 255, 510, 0 on consecutive cycles, then `empty`=1.
- Fill and drop: push 10 values 1 through 10 back-to-back with `out_ready`=0 (`DEPTH`=8). Then `full`=1, `drop_cnt`=2, `acc_total`=36, and the drained sequence is 1 through 8.
- Full push+pop: with the FIFO full of 1 through 8 and `out_ready`=1, push 9. Then `count` stays 8, `drop_cnt` is unchanged, and the drained order is 2 through 9.
- Empty push+pop: with the FIFO empty, hold `in_valid`=1 with 7 and `out_ready`=1 for one cycle. Next cycle `out_valid`=1, `out_data`=7, `count`=1. Wrap check: 20 back-to-back push/pop pairs, each output equals the input from one cycle earlier.
- Saturation and mid-run reset: 300 pushes with no pops; then `drop_cnt`=255 (held) and `acc_total` equals the sum of the first 8 values mod 65536. Assert `rst` for 1 cycle with 5 entries queued: `count`=0 and `drop_cnt`=0 immediately, and the next push of 42 appears alone at the head.
